// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences load/store bursts between the 3BC core and data
// memory. It steers the address-source mux and latches the mux output as the
// burst base. It then issues one strobe per beat and waits a fixed memory
// latency after each strobe. Busy stalls the core until the burst ends.
module dmem_access_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int LEN_W   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic             Clk_i,
  input  logic             Reset_n_i,
  input  logic             Start_i,
  input  logic             IsStore_i,
  input  logic             SrcSel_i,
  input  logic [LEN_W-1:0] Len_i,
  input  logic [AW-1:0]    AddrIn_i,
  input  logic [DW-1:0]    StoreData_i,
  input  logic [DW-1:0]    MemRdData_i,
  output logic             AddrSel_o,
  output logic [AW-1:0]    MemAddr_o,
  output logic             MemRdEn_o,
  output logic             MemWrEn_o,
  output logic [DW-1:0]    MemWrData_o,
  output logic             StoreTake_o,
  output logic [DW-1:0]    LoadData_o,
  output logic             LoadValid_o,
  output logic             Busy_o,
  output logic             Done_o
);

  // Wait counter must be able to hold MEM_LAT; MEM_LAT is at least 1.
  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  // Len == 0 encodes the largest burst, 2^LEN_W beats.
  localparam logic [LEN_W:0] MAX_BEATS = {1'b1, {LEN_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic             sel_q, sel_d;
  logic             dir_q, dir_d;
  logic [LEN_W:0]   beats_q, beats_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [DW-1:0]    loadData_q, loadData_d;
  logic             loadValid_q, loadValid_d;
  logic [LEN_W:0]   idxNext;

  assign idxNext = {1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1};

  // State and burst context registers; reset abandons any in-flight beat.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      sel_q       <= 1'b0;
      dir_q       <= 1'b0;
      beats_q     <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      loadData_q  <= '0;
      loadValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      beats_q     <= beats_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      loadData_q  <= loadData_d;
      loadValid_q <= loadValid_d;
    end
  end

  // Next-state logic: accept in IDLE, one ISSUE cycle per beat, MEM_LAT WAIT cycles, one DONE cycle.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    sel_d       = sel_q;
    dir_d       = dir_q;
    beats_d     = beats_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    loadData_d  = loadData_q;
    loadValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          base_d  = AddrIn_i;
          sel_d   = SrcSel_i;
          dir_d   = IsStore_i;
          beats_d = (Len_i == '0) ? MAX_BEATS : {1'b0, Len_i};
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = CW'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q - CW'(1);
        if (wait_q == CW'(1)) begin
          if (!dir_q) begin
            loadData_d  = MemRdData_i;
            loadValid_d = 1'b1;
          end
          if (idxNext < beats_q) begin
            idx_d   = idxNext[LEN_W-1:0];
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy_o      = (state_q != IDLE);
  assign Done_o      = (state_q == DONE);
  assign AddrSel_o   = Reset_n_i & (Busy_o ? sel_q : SrcSel_i);
  assign MemAddr_o   = base_q + AW'(idx_q);
  assign MemRdEn_o   = (state_q == ISSUE) && !dir_q;
  assign MemWrEn_o   = (state_q == ISSUE) && dir_q;
  assign MemWrData_o = MemWrEn_o ? StoreData_i : '0;
  assign StoreTake_o = MemWrEn_o;
  assign LoadData_o  = loadData_q;
  assign LoadValid_o = loadValid_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed bursts against two instances of the controller.
// One instance uses a memory latency of 1 and the other a latency of 2.
// Each instance has its own small data memory with a registered read.
module tb_dmem_access_ctrl;

  typedef struct {
    bit         useTwo;
    bit         isStore;
    bit         srcSel;
    logic [7:0] addr;
    logic [2:0] len;
    int         expBeats;
    int         expDone;
    bit         poke;
    logic [7:0] firstData;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       memLoad;
  logic       start1, start2, isStore, srcSel;
  logic [2:0] len;
  logic [7:0] addrIn, storeData;
  logic [7:0] rdData1, rdData2;
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  logic       addrSel1, rdEn1, wrEn1, take1, loadValid1, busy1, done1;
  logic [7:0] memAddr1, wrData1, loadData1;
  logic       addrSel2, rdEn2, wrEn2, take2, loadValid2, busy2, done2;
  logic [7:0] memAddr2, wrData2, loadData2;

  bit         useTwo;
  logic       cAddrSel, cRd, cWr, cTake, cLv, cBusy, cDone;
  logic [7:0] cAddr, cWrData, cLoadData;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] storeVals [8];
  vec_t       vecs [6];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DW(8), .AW(8), .LEN_W(3), .MEM_LAT(1)) u1 (
    .Clk_i(clk), .Reset_n_i(rstN), .Start_i(start1), .IsStore_i(isStore),
    .SrcSel_i(srcSel), .Len_i(len), .AddrIn_i(addrIn), .StoreData_i(storeData),
    .MemRdData_i(rdData1), .AddrSel_o(addrSel1), .MemAddr_o(memAddr1),
    .MemRdEn_o(rdEn1), .MemWrEn_o(wrEn1), .MemWrData_o(wrData1),
    .StoreTake_o(take1), .LoadData_o(loadData1), .LoadValid_o(loadValid1),
    .Busy_o(busy1), .Done_o(done1)
  );

  dmem_access_ctrl #(.DW(8), .AW(8), .LEN_W(3), .MEM_LAT(2)) u2 (
    .Clk_i(clk), .Reset_n_i(rstN), .Start_i(start2), .IsStore_i(isStore),
    .SrcSel_i(srcSel), .Len_i(len), .AddrIn_i(addrIn), .StoreData_i(storeData),
    .MemRdData_i(rdData2), .AddrSel_o(addrSel2), .MemAddr_o(memAddr2),
    .MemRdEn_o(rdEn2), .MemWrEn_o(wrEn2), .MemWrData_o(wrData2),
    .StoreTake_o(take2), .LoadData_o(loadData2), .LoadValid_o(loadValid2),
    .Busy_o(busy2), .Done_o(done2)
  );

  // Data memories: preload a known pattern, then apply writes and registered reads.
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 8'(i) ^ 8'h5A;
        mem2[i] <= 8'(i) ^ 8'h5A;
      end
      mem1[8'h40] <= 8'hA5;
    end else begin
      if (wrEn1) mem1[memAddr1] <= wrData1;
      if (wrEn2) mem2[memAddr2] <= wrData2;
    end
    if (rdEn1) rdData1 <= mem1[memAddr1];
    if (rdEn2) rdData2 <= mem2[memAddr2];
  end

  // Route the instance under test onto one set of observation signals.
  always_comb begin
    if (useTwo) begin
      cAddrSel = addrSel2; cRd = rdEn2; cWr = wrEn2; cTake = take2;
      cLv = loadValid2; cBusy = busy2; cDone = done2;
      cAddr = memAddr2; cWrData = wrData2; cLoadData = loadData2;
    end else begin
      cAddrSel = addrSel1; cRd = rdEn1; cWr = wrEn1; cTake = take1;
      cLv = loadValid1; cBusy = busy1; cDone = done1;
      cAddr = memAddr1; cWrData = wrData1; cLoadData = loadData1;
    end
  end

  function automatic logic [7:0] memVal(input bit two, input logic [7:0] a);
    return two ? mem2[a] : mem1[a];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setStart(input logic val);
    if (useTwo) start2 = val;
    else start1 = val;
  endtask

  // Run one burst on the selected instance.
  // Inputs are scrambled after acceptance, and the bench records every strobe and load beat.
  task automatic applyStimulus(input vec_t v);
    logic [7:0] bAddr [8];
    logic [7:0] bData [8];
    logic [7:0] lvData [8];
    int         bCycle [8];
    int strobes, lvCnt, takeCnt, bothCnt, selErr, busyErr, doneCycle, takes, lat;
    bit pending;
    logic [7:0] a;
    strobes = 0; lvCnt = 0; takeCnt = 0; bothCnt = 0; selErr = 0; busyErr = 0;
    doneCycle = -1; takes = 0; pending = 1'b0;
    useTwo = v.useTwo;
    lat = v.useTwo ? 2 : 1;
    @(negedge clk);
    isStore = v.isStore; srcSel = v.srcSel; addrIn = v.addr; len = v.len;
    storeData = storeVals[0];
    #1;
    checkOutput("idleSelPassThrough", 64'(cAddrSel), 64'(v.srcSel));
    setStart(1'b1);
    @(posedge clk); #1;
    setStart(1'b0);
    addrIn = 8'h99; srcSel = ~v.srcSel; len = ~v.len; isStore = ~v.isStore;
    for (int k = 1; k <= 60; k++) begin
      if (pending) begin
        if (takes < 8) storeData = storeVals[takes];
        pending = 1'b0;
      end
      if (cRd && cWr) bothCnt++;
      if (cRd || cWr) begin
        if (strobes < 8) begin
          bAddr[strobes] = cAddr; bData[strobes] = cWrData; bCycle[strobes] = k;
        end
        strobes++;
      end
      if (cTake) begin takeCnt++; takes++; pending = 1'b1; end
      if (cLv) begin
        if (lvCnt < 8) lvData[lvCnt] = cLoadData;
        lvCnt++;
      end
      if (cAddrSel !== v.srcSel) selErr++;
      if (cBusy !== 1'b1) busyErr++;
      setStart(v.poke && (k == 2 || cDone === 1'b1));
      if (cDone === 1'b1) begin
        doneCycle = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (doneCycle < 0) $display("[TB] FAIL doneTimeout: got no Done, expected Done in cycle %0d", v.expDone);
    @(posedge clk); #1;
    setStart(1'b0);
    checkOutput("idleAfterDone", {60'd0, cBusy, cDone, cRd, cWr}, 64'd0);
    checkOutput("doneCycle", 64'(doneCycle), 64'(v.expDone));
    checkOutput("strobeCount", 64'(strobes), 64'(v.expBeats));
    checkOutput("storeTakeCount", 64'(takeCnt), 64'(v.isStore ? v.expBeats : 0));
    checkOutput("loadValidCount", 64'(lvCnt), 64'(v.isStore ? 0 : v.expBeats));
    checkOutput("strobeOverlap", 64'(bothCnt), 64'd0);
    checkOutput("latchedAddrSel", 64'(selErr), 64'd0);
    checkOutput("busyDuringBurst", 64'(busyErr), 64'd0);
    for (int i = 0; i < v.expBeats && i < 8; i++) begin
      a = v.addr + 8'(i);
      checkOutput($sformatf("beatAddr[%0d]", i), 64'(bAddr[i]), 64'(a));
      checkOutput($sformatf("beatCycle[%0d]", i), 64'(bCycle[i]), 64'(1 + i * (1 + lat)));
      if (v.isStore) begin
        checkOutput($sformatf("writeData[%0d]", i), 64'(bData[i]), 64'(storeVals[i]));
        checkOutput($sformatf("memAfterWrite[%0d]", i), 64'(memVal(v.useTwo, a)), 64'(storeVals[i]));
      end else begin
        checkOutput($sformatf("loadData[%0d]", i), 64'(lvData[i]), 64'(memVal(v.useTwo, a)));
      end
    end
    if (v.isStore) checkOutput("firstWrite", 64'(bData[0]), 64'(v.firstData));
    else begin
      checkOutput("firstLoad", 64'(lvData[0]), 64'(v.firstData));
      a = v.addr + 8'(v.expBeats - 1);
      checkOutput("loadDataHold", 64'(cLoadData), 64'(memVal(v.useTwo, a)));
    end
  endtask

  initial begin
    storeVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h40, 3'd1, 1, 3, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h10, 3'd3, 3, 10, 1'b0, 8'h11};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'hFE, 3'd0, 8, 17, 1'b0, 8'hA4};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h20, 3'd2, 2, 5, 1'b1, 8'h7A};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'hFF, 3'd2, 2, 5, 1'b1, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h11, 3'd2, 2, 7, 1'b0, 8'h22};

    useTwo = 1'b0;
    rstN = 1'b0; memLoad = 1'b1;
    start1 = 1'b0; start2 = 1'b0; isStore = 1'b0; srcSel = 1'b1;
    len = 3'd0; addrIn = 8'h00; storeData = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetStateU1", {33'd0, addrSel1, memAddr1, rdEn1, wrEn1, wrData1, take1, loadData1, loadValid1, busy1, done1}, 64'd0);
    checkOutput("resetStateU2", {33'd0, addrSel2, memAddr2, rdEn2, wrEn2, wrData2, take2, loadData2, loadValid2, busy2, done2}, 64'd0);
    @(negedge clk);
    memLoad = 1'b0; rstN = 1'b1; srcSel = 1'b0;

    // Reset in the WAIT cycle of beat 1 of a 4-beat load.
    // All outputs must clear and no stale pulse may follow.
    @(negedge clk);
    srcSel = 1'b1; addrIn = 8'h30; len = 3'd4; isStore = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midBurstBusy", 64'(busy1), 64'd1);
    checkOutput("midBurstLoadData", 64'(loadData1), 64'(8'h30 ^ 8'h5A));
    rstN = 1'b0;
    #1;
    checkOutput("resetMidBurst", {33'd0, addrSel1, memAddr1, rdEn1, wrEn1, wrData1, take1, loadData1, loadValid1, busy1, done1}, 64'd0);
    @(negedge clk);
    rstN = 1'b1; srcSel = 1'b0;
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done1 || loadValid1 || busy1 || rdEn1) stale++;
      end
      checkOutput("noStaleAfterReset", 64'(stale), 64'd0);
    end

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences load/store bursts between the 3BC core and data memory.
- Drives the select line of the 2:1 address-source mux and latches the mux output as the burst base address.
- Issues one memory read or write per beat, waits a fixed memory latency, then returns load data or consumes store data.
- Holds the core stalled via Busy until the burst completes.

Parameters:
- DW, 8, data width.
- AW, 8, address width.
- LEN_W, 3, burst-length field width. Len==0 encodes 2^LEN_W beats.
- MEM_LAT, 1, wait cycles after each issue cycle. Legal range ≥1.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- IsStore  in  1  1 = store burst, 0 = load burst; sampled with Start.
- SrcSel  in  1  address-source select request; sampled with Start.
- Len  in  LEN_W  beat count; sampled with Start.
- AddrIn  in  AW  output of the address mux.
- StoreData  in  DW  store beat data, held valid by the core.
- MemRdData  in  DW  read data from data memory.
- AddrSel  out  1  select to the address mux.
- MemAddr  out  AW  memory address.
- MemRdEn  out  1  memory read strobe.
- MemWrEn  out  1  memory write strobe.
- MemWrData  out  DW  memory write data.
- StoreTake  out  1  pulse: current StoreData consumed.
- LoadData  out  DW  captured load beat.
- LoadValid  out  1  pulse: LoadData valid.
- Busy  out  1  core stall.
- Done  out  1  pulse: burst finished.

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE.
  - All outputs 0, including LoadData, MemAddr and the latched selector.
  - In-flight beat abandoned; no Done pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - AddrSel = SrcSel (combinational pass-through), so AddrIn is valid in the same cycle.
  - On Start=1, latch: base←AddrIn, sel←SrcSel, dir←IsStore, beats←(Len==0 ? 2^LEN_W : Len), beat index←0.
  - Next state ISSUE. Busy rises the cycle after Start.
- ISSUE (exactly one cycle per beat):
  - MemAddr = base + index, modulo 2^AW; 0xFF+1 wraps to 0x00.
  - Load: MemRdEn=1.
  - Store: MemWrEn=1, MemWrData=StoreData, StoreTake=1 in the same cycle.
  - Next state WAIT; wait counter loaded with MEM_LAT.
- WAIT:
  - Strobes 0; MemAddr holds the beat address.
  - Counter decrements each cycle.
  - In the last WAIT cycle, a load captures MemRdData into LoadData. LoadValid=1 for the following single cycle.
  - At the end of WAIT: if index+1 < beats, increment index and go to ISSUE; otherwise go to DONE.
- DONE (one cycle): Done=1, Busy=1; next state IDLE.
- Busy=1 in ISSUE, WAIT and DONE; 0 in IDLE.
- AddrSel = latched sel while Busy.
- Latency per beat = 1 + MEM_LAT cycles.
- Burst total = 1 (accept) + beats·(1+MEM_LAT) + 1 (DONE) cycles from Start to Done.
- Start while Busy is ignored; no queueing.
- Start asserted in the DONE cycle is also ignored; a new burst can be accepted in the cycle after Done.
- Strobe exclusivity:
  - MemRdEn and MemWrEn are never 1 together.
  - Neither strobe is 1 outside ISSUE.
  - At most one strobe per beat.
- LoadValid never asserts for stores; StoreTake never asserts for loads.
- LoadData holds its last value until the next load capture.
- Changes on AddrIn, SrcSel, Len or IsStore after acceptance have no effect on the current burst.

Test Plan:
- Reset_n=0 mid-WAIT of a 4-beat load → next edge-independent: all outputs 0, state IDLE. After release, Start works normally and no stale Done/LoadValid appears.
- Single load, MEM_LAT=1: SrcSel=1, AddrIn=0x40, Len=1, memory[0x40]=0xA5 →
  - AddrSel=1 throughout.
  - MemRdEn=1 with MemAddr=0x40 for one cycle.
  - LoadData=0xA5 with LoadValid pulse.
  - Done 4 cycles after Start.
- Store burst, MEM_LAT=2: SrcSel=0, AddrIn=0x10, Len=3, StoreData changed to 0x11/0x22/0x33 on each StoreTake →
  - Writes 0x10=0x11, 0x11=0x22, 0x12=0x33.
  - Exactly 3 MemWrEn pulses, spaced 3 cycles apart.
  - Done at cycle 11 after Start.
- Wrap and Len=0: AddrIn=0xFE, Len=0, load →
  - 8 beats at 0xFE, 0xFF, 0x00…0x05.
  - 8 LoadValid pulses carrying matching memory contents.
- Start pulsed while Busy, and again in the DONE cycle → both ignored: no extra strobes, Busy drops after Done. A Start the following cycle is accepted.
- Inputs changed after acceptance: AddrIn→0x99, SrcSel flipped mid-burst → addresses continue from the latched base and AddrSel stays at the latched value.
